// File: rtl/vga_timing_ctrl_pkg.sv
// Shared display timing package.
// Holds the 640x480@60 timing constants and the pixel-pipeline latency of
// the frame decoder, so the decoder and the timing generator cannot drift.
// Also holds the bundle of per-pixel sync flags carried through the
// alignment delay line.
package vga_timing_ctrl_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Clocks from the counter value that produces a coordinate to the
    // matching colour on i_decoded_color. The coordinate output register
    // of vga_timing_ctrl is the first of these stages.
    localparam int PIPE_LATENCY = 2;

    localparam int MAP_H_WIDTH = $clog2(H_ACTIVE);
    localparam int MAP_V_WIDTH = $clog2(V_ACTIVE);

    typedef struct packed {
        logic active;
        logic hs_n;
        logic vs_n;
    } sync_bits_t;

    localparam sync_bits_t SYNC_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

    // True when start <= cnt < start + len.
    function automatic logic in_window(input int cnt, input int start, input int len);
        return (cnt >= start) && (cnt < start + len);
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// N-deep, W-wide shift register with an asynchronous reset value.
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset, loads rst_val into every stage
//   rst_val  value held by every stage while in reset
//   din      input word
//   dout     din delayed by N clocks
module vga_sync_delay #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] rst_val,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                stage[i] <= rst_val;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < N; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[N-1];

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator and DAC output stage around the frame decoder.
// Counts pixels/lines, issues active-area coordinates to the decoder,
// delays the region flags to meet the decoded colour, and registers the
// DAC pins. Counter-to-pin latency is PIPE_LATENCY+1 for colour, BLANK_N,
// HS and VS alike.
// Ports:
//   i_clk            pixel clock
//   i_rst_n          asynchronous active-low reset
//   o_VGA_H/o_VGA_V  active-area coordinate to the decoder, 0 while blanking
//   i_decoded_color  {R,G,B} from the decoder
//   o_VGA_R/G/B      registered DAC colour, 0 while blanking
//   o_VGA_HS/VS      active-low syncs
//   o_VGA_BLANK_N    high while the displayed pixel is active
//   o_VGA_SYNC_N     tied low (no sync-on-green)
//   o_frame_start    one-clock pulse as the vertical front porch begins
module vga_timing_ctrl
    import vga_timing_ctrl_pkg::*;
#(
    parameter int H_ACT = H_ACTIVE,
    parameter int H_FP  = H_FRONT,
    parameter int H_SW  = H_SYNC,
    parameter int H_BP  = H_BACK,
    parameter int V_ACT = V_ACTIVE,
    parameter int V_FP  = V_FRONT,
    parameter int V_SW  = V_SYNC,
    parameter int V_BP  = V_BACK
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    output logic [MAP_H_WIDTH-1:0] o_VGA_H,
    output logic [MAP_V_WIDTH-1:0] o_VGA_V,
    input  logic [23:0]            i_decoded_color,
    output logic [7:0]             o_VGA_R,
    output logic [7:0]             o_VGA_G,
    output logic [7:0]             o_VGA_B,
    output logic                   o_VGA_HS,
    output logic                   o_VGA_VS,
    output logic                   o_VGA_BLANK_N,
    output logic                   o_VGA_SYNC_N,
    output logic                   o_frame_start
);

    localparam int H_TOT = H_ACT + H_FP + H_SW + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SW + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_last;
    logic          v_last;

    assign h_last = (h_cnt == HW'(H_TOT - 1));
    assign v_last = (v_cnt == VW'(V_TOT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    sync_bits_t stage0;
    sync_bits_t aligned;

    always_comb begin
        stage0.active = in_window(int'(h_cnt), 0, H_ACT) && in_window(int'(v_cnt), 0, V_ACT);
        stage0.hs_n   = !in_window(int'(h_cnt), H_ACT + H_FP, H_SW);
        stage0.vs_n   = !in_window(int'(v_cnt), V_ACT + V_FP, V_SW);
    end

    // The delayed flags line up with the colour present on i_decoded_color,
    // so both can be captured by the same output register.
    vga_sync_delay #(
        .N (PIPE_LATENCY),
        .W ($bits(sync_bits_t))
    ) u_sync_delay (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .rst_val (SYNC_IDLE),
        .din     (stage0),
        .dout    (aligned)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_VGA_H       <= '0;
            o_VGA_V       <= '0;
            o_VGA_R       <= 8'h00;
            o_VGA_G       <= 8'h00;
            o_VGA_B       <= 8'h00;
            o_VGA_HS      <= 1'b1;
            o_VGA_VS      <= 1'b1;
            o_VGA_BLANK_N <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            // Zero while blanking keeps the decoder's map lookup in range.
            o_VGA_H       <= stage0.active ? MAP_H_WIDTH'(h_cnt) : '0;
            o_VGA_V       <= stage0.active ? MAP_V_WIDTH'(v_cnt) : '0;
            o_VGA_R       <= aligned.active ? i_decoded_color[23:16] : 8'h00;
            o_VGA_G       <= aligned.active ? i_decoded_color[15:8]  : 8'h00;
            o_VGA_B       <= aligned.active ? i_decoded_color[7:0]   : 8'h00;
            o_VGA_HS      <= aligned.hs_n;
            o_VGA_VS      <= aligned.vs_n;
            o_VGA_BLANK_N <= aligned.active;
            // Not delayed: high on the cycle the counters read (0, V_ACT),
            // giving game logic the whole vertical blanking interval.
            o_frame_start <= h_last && (v_cnt == VW'(V_ACT - 1));
        end
    end

    assign o_VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl. Horizontal timing is the full
// 800-clock line; the vertical timing is shortened (12 lines) so that
// several frames fit in a short run. After each reset release (done on a
// falling clock edge) cyc counts rising edges, so a sample taken on the
// falling edge sees counter index cyc and pins reflecting index cyc-3.
module tb_vga_timing_ctrl;
    import vga_timing_ctrl_pkg::*;

    localparam int T_HA  = 640;
    localparam int T_HF  = 16;
    localparam int T_HSW = 96;
    localparam int T_HB  = 48;
    localparam int T_HT  = 800;
    localparam int T_VA  = 6;
    localparam int T_VF  = 2;
    localparam int T_VSW = 2;
    localparam int T_VB  = 2;
    localparam int T_VT  = 12;
    localparam int LAT   = 3;
    localparam int FRAME = T_HT * T_VT;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [MAP_H_WIDTH-1:0] vga_h;
    logic [MAP_V_WIDTH-1:0] vga_v;
    logic [23:0]            dec_color;
    logic [7:0]             vga_r, vga_g, vga_b;
    logic                   vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start;

    int cyc;
    int n_checks = 0;
    int n_fail = 0;
    bit color_mode = 1'b0;

    vga_timing_ctrl #(
        .H_ACT (T_HA), .H_FP (T_HF), .H_SW (T_HSW), .H_BP (T_HB),
        .V_ACT (T_VA), .V_FP (T_VF), .V_SW (T_VSW), .V_BP (T_VB)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .o_VGA_H         (vga_h),
        .o_VGA_V         (vga_v),
        .i_decoded_color (dec_color),
        .o_VGA_R         (vga_r),
        .o_VGA_G         (vga_g),
        .o_VGA_B         (vga_b),
        .o_VGA_HS        (vga_hs),
        .o_VGA_VS        (vga_vs),
        .o_VGA_BLANK_N   (vga_blank_n),
        .o_VGA_SYNC_N    (vga_sync_n),
        .o_frame_start   (frame_start)
    );

    always #20 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Decoder model: one register after the coordinate pins.
    always @(posedge clk) begin
        dec_color <= color_mode ? 24'hFFFFFF : {vga_h[7:0], 16'h0000};
    end

    function automatic bit exp_blank_n(int n);
        int p, h, v;
        if (n < LAT) return 1'b0;
        p = n - LAT; h = p % T_HT; v = (p / T_HT) % T_VT;
        return (h < T_HA) && (v < T_VA);
    endfunction

    function automatic bit exp_hs_n(int n);
        int h;
        if (n < LAT) return 1'b1;
        h = (n - LAT) % T_HT;
        return !((h >= T_HA + T_HF) && (h < T_HA + T_HF + T_HSW));
    endfunction

    function automatic bit exp_vs_n(int n);
        int v;
        if (n < LAT) return 1'b1;
        v = ((n - LAT) / T_HT) % T_VT;
        return !((v >= T_VA + T_VF) && (v < T_VA + T_VF + T_VSW));
    endfunction

    function automatic int exp_coord_h(int n);
        int p, h, v;
        if (n < 1) return 0;
        p = n - 1; h = p % T_HT; v = (p / T_HT) % T_VT;
        return ((h < T_HA) && (v < T_VA)) ? h : 0;
    endfunction

    function automatic int exp_coord_v(int n);
        int p, h, v;
        if (n < 1) return 0;
        p = n - 1; h = p % T_HT; v = (p / T_HT) % T_VT;
        return ((h < T_HA) && (v < T_VA)) ? v : 0;
    endfunction

    function automatic bit exp_fs(int n);
        return (n >= 1) && ((n % FRAME) == T_VA * T_HT);
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (vga_hs !== 1'b1) begin n_fail++; $display("FAIL reset_hs: got %0b, expected 1", vga_hs); end
        n_checks++; if (vga_vs !== 1'b1) begin n_fail++; $display("FAIL reset_vs: got %0b, expected 1", vga_vs); end
        n_checks++; if (vga_blank_n !== 1'b0) begin n_fail++; $display("FAIL reset_blank_n: got %0b, expected 0", vga_blank_n); end
        n_checks++; if ({vga_r, vga_g, vga_b} !== 24'h0) begin n_fail++; $display("FAIL reset_rgb: got %06h, expected 000000", {vga_r, vga_g, vga_b}); end
        n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: got %0b, expected 0", frame_start); end
        n_checks++; if (vga_h !== '0 || vga_v !== '0) begin n_fail++; $display("FAIL reset_coord: got (%0d,%0d), expected (0,0)", vga_h, vga_v); end
        n_checks++; if (vga_sync_n !== 1'b0) begin n_fail++; $display("FAIL sync_n_tied: got %0b, expected 0", vga_sync_n); end
    endtask

    task automatic test_hsync_timing();
        int fall0 = -1, fall1 = -1, rise0 = -1, blank_hi = 0, model_err = 0;
        bit prev;
        color_mode = 1'b0;
        apply_reset();
        prev = vga_hs;
        for (int i = 0; i < 1700; i++) begin
            @(negedge clk);
            if (prev && !vga_hs) begin
                if (fall0 < 0) fall0 = cyc;
                else if (fall1 < 0) fall1 = cyc;
            end
            if (!prev && vga_hs && rise0 < 0) rise0 = cyc;
            prev = vga_hs;
            if (cyc < T_HT && vga_blank_n) blank_hi++;
            if (vga_blank_n !== exp_blank_n(cyc) || vga_hs !== exp_hs_n(cyc) || vga_vs !== exp_vs_n(cyc)) model_err++;
        end
        n_checks++; if (fall0 !== T_HA + T_HF + LAT) begin n_fail++; $display("FAIL hs_first_fall: got %0d, expected %0d", fall0, T_HA + T_HF + LAT); end
        n_checks++; if (rise0 - fall0 !== T_HSW) begin n_fail++; $display("FAIL hs_low_width: got %0d, expected %0d", rise0 - fall0, T_HSW); end
        n_checks++; if (fall1 - fall0 !== T_HT) begin n_fail++; $display("FAIL h_period: got %0d, expected %0d", fall1 - fall0, T_HT); end
        n_checks++; if (blank_hi !== T_HA) begin n_fail++; $display("FAIL line0_blank_high: got %0d, expected %0d", blank_hi, T_HA); end
        n_checks++; if (model_err !== 0) begin n_fail++; $display("FAIL sync_vs_model: got %0d bad samples, expected 0", model_err); end
    endtask

    task automatic test_color_ramp();
        int ramp_err = 0;
        color_mode = 1'b0;
        apply_reset();
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (cyc >= LAT && cyc < LAT + T_HA) begin
                if (vga_r !== 8'(cyc - LAT) || vga_g !== 8'h0 || vga_b !== 8'h0) ramp_err++;
            end
            if (cyc == LAT - 1) begin
                n_checks++; if (vga_blank_n !== 1'b0) begin n_fail++; $display("FAIL ramp_pre_blank: got %0b, expected 0", vga_blank_n); end
            end
            if (cyc == LAT) begin
                n_checks++; if (vga_blank_n !== 1'b1 || vga_r !== 8'd0) begin n_fail++; $display("FAIL ramp_x0: got blank_n=%0b r=%0d, expected 1 and 0", vga_blank_n, vga_r); end
            end
            if (cyc == LAT + 255) begin
                n_checks++; if (vga_r !== 8'd255) begin n_fail++; $display("FAIL ramp_x255: got %0d, expected 255", vga_r); end
            end
            if (cyc == LAT + 256) begin
                n_checks++; if (vga_r !== 8'd0) begin n_fail++; $display("FAIL ramp_x256: got %0d, expected 0", vga_r); end
            end
            if (cyc == LAT + T_HA - 1) begin
                n_checks++; if (vga_blank_n !== 1'b1 || vga_r !== 8'd127) begin n_fail++; $display("FAIL ramp_x639: got blank_n=%0b r=%0d, expected 1 and 127", vga_blank_n, vga_r); end
            end
            if (cyc == LAT + T_HA) begin
                n_checks++; if (vga_blank_n !== 1'b0 || vga_r !== 8'd0) begin n_fail++; $display("FAIL ramp_x640: got blank_n=%0b r=%0d, expected 0 and 0", vga_blank_n, vga_r); end
            end
        end
        n_checks++; if (ramp_err !== 0) begin n_fail++; $display("FAIL ramp_line: got %0d bad pixels, expected 0", ramp_err); end
    endtask

    task automatic test_white_blank();
        int line_hi [T_VT];
        int rgb_err = 0, line_err = 0, model_err = 0, vs_low = 0, vs_fall = -1, line;
        color_mode = 1'b1;
        for (int l = 0; l < T_VT; l++) line_hi[l] = 0;
        apply_reset();
        for (int i = 0; i < FRAME + LAT; i++) begin
            @(negedge clk);
            if (vga_blank_n === 1'b1 && {vga_r, vga_g, vga_b} !== 24'hFFFFFF) rgb_err++;
            if (vga_blank_n !== 1'b1 && {vga_r, vga_g, vga_b} !== 24'h000000) rgb_err++;
            if (vga_blank_n !== exp_blank_n(cyc) || vga_vs !== exp_vs_n(cyc)) model_err++;
            if (cyc >= LAT && cyc < FRAME + LAT) begin
                line = (cyc - LAT) / T_HT;
                if (vga_blank_n) line_hi[line]++;
                if (!vga_vs) begin
                    vs_low++;
                    if (vs_fall < 0) vs_fall = cyc;
                end
            end
        end
        for (int l = 0; l < T_VT; l++) begin
            if (line_hi[l] !== ((l < T_VA) ? T_HA : 0)) line_err++;
        end
        n_checks++; if (rgb_err !== 0) begin n_fail++; $display("FAIL white_rgb_gating: got %0d bad samples, expected 0", rgb_err); end
        n_checks++; if (line_hi[0] !== T_HA) begin n_fail++; $display("FAIL white_line0_high: got %0d, expected %0d", line_hi[0], T_HA); end
        n_checks++; if (line_hi[T_VA] !== 0) begin n_fail++; $display("FAIL white_vblank_line_high: got %0d, expected 0", line_hi[T_VA]); end
        n_checks++; if (line_err !== 0) begin n_fail++; $display("FAIL white_lines: got %0d wrong lines, expected 0", line_err); end
        n_checks++; if (vs_low !== T_VSW * T_HT) begin n_fail++; $display("FAIL vs_low_clocks: got %0d, expected %0d", vs_low, T_VSW * T_HT); end
        n_checks++; if (vs_fall !== LAT + (T_VA + T_VF) * T_HT) begin n_fail++; $display("FAIL vs_first_fall: got %0d, expected %0d", vs_fall, LAT + (T_VA + T_VF) * T_HT); end
        n_checks++; if (model_err !== 0) begin n_fail++; $display("FAIL white_vs_model: got %0d bad samples, expected 0", model_err); end
    endtask

    task automatic test_blank_coords();
        int coord_err = 0;
        color_mode = 1'b0;
        apply_reset();
        for (int i = 0; i < FRAME + 2; i++) begin
            @(negedge clk);
            if (vga_h !== MAP_H_WIDTH'(exp_coord_h(cyc)) || vga_v !== MAP_V_WIDTH'(exp_coord_v(cyc))) coord_err++;
            if (cyc == 1) begin
                n_checks++; if (vga_h !== 10'd0 || vga_v !== 9'd0) begin n_fail++; $display("FAIL coord_origin: got (%0d,%0d), expected (0,0)", vga_h, vga_v); end
            end
            if (cyc == T_HA) begin
                n_checks++; if (vga_h !== 10'd639 || vga_v !== 9'd0) begin n_fail++; $display("FAIL coord_row0_end: got (%0d,%0d), expected (639,0)", vga_h, vga_v); end
            end
            if (cyc == 3 * T_HT + 101) begin
                n_checks++; if (vga_h !== 10'd100 || vga_v !== 9'd3) begin n_fail++; $display("FAIL coord_mid: got (%0d,%0d), expected (100,3)", vga_h, vga_v); end
            end
            if (cyc == (T_VA - 1) * T_HT + T_HA) begin
                n_checks++; if (vga_h !== 10'd639 || vga_v !== MAP_V_WIDTH'(T_VA - 1)) begin n_fail++; $display("FAIL coord_last_active: got (%0d,%0d), expected (639,%0d)", vga_h, vga_v, T_VA - 1); end
            end
            if (cyc == (T_VA - 1) * T_HT + T_HA + 1) begin
                n_checks++; if (vga_h !== 10'd0 || vga_v !== 9'd0) begin n_fail++; $display("FAIL coord_hblank: got (%0d,%0d), expected (0,0)", vga_h, vga_v); end
            end
            if (cyc == T_VA * T_HT + 1) begin
                n_checks++; if (vga_h !== 10'd0 || vga_v !== 9'd0) begin n_fail++; $display("FAIL coord_vblank: got (%0d,%0d), expected (0,0)", vga_h, vga_v); end
            end
        end
        n_checks++; if (coord_err !== 0) begin n_fail++; $display("FAIL coord_frame: got %0d bad samples, expected 0", coord_err); end
    endtask

    task automatic test_frame_start();
        int rises [4];
        int n_rise = 0, n_high = 0, model_err = 0;
        bit prev = 1'b0;
        color_mode = 1'b0;
        for (int k = 0; k < 4; k++) rises[k] = -1;
        apply_reset();
        for (int i = 0; i < 3 * FRAME + 10; i++) begin
            @(negedge clk);
            if (frame_start) n_high++;
            if (frame_start && !prev) begin
                if (n_rise < 4) rises[n_rise] = cyc;
                n_rise++;
            end
            prev = frame_start;
            if (frame_start !== exp_fs(cyc)) model_err++;
        end
        n_checks++; if (n_rise !== 3) begin n_fail++; $display("FAIL fs_pulse_count: got %0d, expected 3", n_rise); end
        n_checks++; if (n_high !== 3) begin n_fail++; $display("FAIL fs_high_clocks: got %0d, expected 3", n_high); end
        n_checks++; if (rises[0] !== T_VA * T_HT) begin n_fail++; $display("FAIL fs_first_index: got %0d, expected %0d", rises[0], T_VA * T_HT); end
        n_checks++; if (rises[1] - rises[0] !== FRAME) begin n_fail++; $display("FAIL fs_spacing_1: got %0d, expected %0d", rises[1] - rises[0], FRAME); end
        n_checks++; if (rises[2] - rises[1] !== FRAME) begin n_fail++; $display("FAIL fs_spacing_2: got %0d, expected %0d", rises[2] - rises[1], FRAME); end
        n_checks++; if (model_err !== 0) begin n_fail++; $display("FAIL fs_vs_model: got %0d bad samples, expected 0", model_err); end
    endtask

    task automatic test_reset_mid_frame();
        color_mode = 1'b1;
        apply_reset();
        repeat (4 * T_HT + 300) @(negedge clk);
        n_checks++; if (vga_blank_n !== 1'b1 || vga_r !== 8'hFF) begin n_fail++; $display("FAIL pre_reset_active: got blank_n=%0b r=%0h, expected 1 and ff", vga_blank_n, vga_r); end
        n_checks++; if (vga_h !== 10'd299 || vga_v !== 9'd4) begin n_fail++; $display("FAIL pre_reset_coord: got (%0d,%0d), expected (299,4)", vga_h, vga_v); end
        #5;
        rst_n = 1'b0;
        #1;
        n_checks++; if (vga_blank_n !== 1'b0) begin n_fail++; $display("FAIL async_blank_n: got %0b, expected 0", vga_blank_n); end
        n_checks++; if ({vga_r, vga_g, vga_b} !== 24'h0) begin n_fail++; $display("FAIL async_rgb: got %06h, expected 000000", {vga_r, vga_g, vga_b}); end
        n_checks++; if (vga_hs !== 1'b1 || vga_vs !== 1'b1) begin n_fail++; $display("FAIL async_syncs: got hs=%0b vs=%0b, expected 1 and 1", vga_hs, vga_vs); end
        n_checks++; if (vga_h !== '0 || vga_v !== '0) begin n_fail++; $display("FAIL async_coord: got (%0d,%0d), expected (0,0)", vga_h, vga_v); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (vga_blank_n !== (cyc >= LAT)) begin n_fail++; $display("FAIL restart_blank_n_%0d: got %0b, expected %0b", cyc, vga_blank_n, cyc >= LAT); end
            n_checks++; if (vga_h !== MAP_H_WIDTH'(cyc - 1) || vga_v !== '0) begin n_fail++; $display("FAIL restart_coord_%0d: got (%0d,%0d), expected (%0d,0)", cyc, vga_h, vga_v, cyc - 1); end
            if (cyc == LAT) begin
                n_checks++; if (vga_r !== 8'hFF) begin n_fail++; $display("FAIL restart_first_pixel: got %0h, expected ff", vga_r); end
            end
        end
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_hsync_timing();
        test_color_ramp();
        test_white_blank();
        test_blank_coords();
        test_frame_start();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Pixel-clock VGA timing generator and output stage wrapped around the frame decoder.
- Upstream role: drives the active-area coordinates (VGA_H/VGA_V) into the frame decoder.
- Downstream role: captures the decoded 24-bit colour, realigns sync/blank with the decoder's pipeline latency, and registers the DAC outputs.
- Emits a once-per-frame pulse so game logic can update car state during vertical blanking.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BACK, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BACK, 33, vertical back porch
- PIPE_LATENCY, 2, clocks from a coordinate leaving this block to its colour being valid on i_decoded_color

Ports:
- i_clk  in  1  pixel clock (25 MHz)
- i_rst_n  in  1  asynchronous active-low reset
- o_VGA_H  out  MAP_H_WIDTH  active-area x coordinate to frame decoder
- o_VGA_V  out  MAP_V_WIDTH  active-area y coordinate to frame decoder
- i_decoded_color  in  24  {R,G,B} from frame decoder, PIPE_LATENCY after coordinate
- o_VGA_R / o_VGA_G / o_VGA_B  out  8 each  registered DAC colour
- o_VGA_HS  out  1  horizontal sync, active low
- o_VGA_VS  out  1  vertical sync, active low
- o_VGA_BLANK_N  out  1  high while displayed pixel is active
- o_VGA_SYNC_N  out  1  tied 0 (no sync-on-green)
- o_frame_start  out  1  one-clock pulse at start of vertical front porch

Behaviour:
- Interface fixed: single clock i_clk; reset i_rst_n is asynchronous, active-low.
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of H params (800).
  - v_cnt runs 0..V_TOTAL-1 (525).
  - v_cnt increments only when h_cnt wraps from H_TOTAL-1 to 0.
  - v_cnt wraps to 0 on the same edge where h_cnt wraps and v_cnt = V_TOTAL-1.
  - Counter width is $clog2 of the total. Compares are unsigned; no overflow beyond the total.
- Region decode (stage 0, combinational from counters):
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs_n = 0 iff H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC.
  - vs_n = 0 under the same rule applied to v_cnt with the V params.
- Coordinate output:
  - o_VGA_H/o_VGA_V are registered copies of h_cnt/v_cnt while active.
  - During blanking they are forced to 0, so the decoder never indexes off-map.
- Alignment:
  - active, hs_n and vs_n pass through a shift register of depth PIPE_LATENCY.
  - The colour for coordinate issued at cycle t is sampled at t+PIPE_LATENCY.
  - That sample is registered together with the delayed active/hs_n/vs_n.
  - Total latency, counter to pins: PIPE_LATENCY+1 clocks, identical for colour, BLANK_N, HS and VS.
- Blanking colour: when the delayed active bit is 0, o_VGA_R/G/B = 0 regardless of i_decoded_color.
- o_frame_start:
  - Pulses high for exactly one clock on the cycle v_cnt becomes V_ACTIVE with h_cnt = 0.
  - Undelayed, so game logic gets the full blanking interval.
- Reset values:
  - Counters 0 and all pipeline bits cleared (active=0, hs_n=1, vs_n=1).
  - o_VGA_R/G/B = 0, o_VGA_HS = 1, o_VGA_VS = 1, o_VGA_BLANK_N = 0, o_frame_start = 0, o_VGA_H = o_VGA_V = 0.
- Reset mid-frame: all of the above take effect immediately, asynchronously. After release, the timing restarts at pixel (0,0). The first PIPE_LATENCY+1 outputs are blank.
- No FSM beyond the counters; region flags are pure decodes.

Decomposition:
- Shared package (display/VGA package alongside sram_pkg): the eight timing constants, H_TOTAL, V_TOTAL, and PIPE_LATENCY.
- PIPE_LATENCY is owned there so the frame decoder and this block cannot drift.
- One natural sub-module: vga_sync_delay, a parameterised N-deep, W-wide shift register with async reset value input, used for the active/hs_n/vs_n alignment.

Test Plan:
1. Reset release, run one full frame:
   - h_cnt period is 800 clocks; v period is 420000 clocks.
   - o_VGA_HS low for exactly 96 clocks, starting 656+3 clocks after line start.
   - o_VGA_VS low for exactly 2 lines.
2. Drive i_decoded_color = {8'(h_cnt of issued coordinate), 16'h0} via a model with PIPE_LATENCY=2:
   - o_VGA_R equals 0..255 ramp aligned with o_VGA_BLANK_N rising.
   - Expect no off-by-one at x=0 or x=639.
3. Hold i_decoded_color = 24'hFFFFFF constantly:
   - o_VGA_R/G/B = 0 whenever o_VGA_BLANK_N = 0.
   - 0xFF when it is 1; exactly 640 high clocks per active line.
4. Count o_frame_start across 3 frames:
   - Exactly 3 single-cycle pulses, 420000 clocks apart.
   - Each coincides with v_cnt = 480, h_cnt = 0.
5. Assert i_rst_n low at v=200, h=300:
   - Outputs go to reset values without waiting for a clock edge.
   - After release, first BLANK_N high occurs at clock 3; o_VGA_H/V restart at 0.
6. Blanking coordinates:
   - During h_cnt >= 640 or v_cnt >= 480, o_VGA_H = o_VGA_V = 0.
   - At (639,479), o_VGA_H = 639 and o_VGA_V = 479.
